// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK flip-flops: clear, load and
// count up/down (via JK toggle masks derived from the bank's Q read-back).
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CW-1:0]    cmd_steps_i,
  input  logic [WIDTH-1:0] q_vec_i,
  output logic [WIDTH-1:0] j_vec_c_o,
  output logic [WIDTH-1:0] k_vec_c_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrapped_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [1:0] {OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             wrapped_q, wrapped_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mask_c;
  logic             chain_c;

  // Toggle mask: bit i flips when all lower bits are 1 (up) or 0 (down).
  // The chain left over after the top bit means the whole vector is at the wrap value.
  always_comb begin
    mask_c  = '0;
    chain_c = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      mask_c[i] = chain_c;
      chain_c   = chain_c & ((op_q == OP_UP) ? q_vec_i[i] : ~q_vec_i[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLEAR;
      data_q    <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
      wrapped_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      wrapped_q <= wrapped_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    wrap_d    = wrap_q;
    wrapped_d = wrapped_q;
    j_vec_c_o = '0;
    k_vec_c_o = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d      = op_e'(cmd_op_i);
          data_d    = cmd_data_i;
          cnt_d     = cmd_steps_i;
          wrap_d    = 1'b0;
          wrapped_d = 1'b0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_CLEAR: begin
            k_vec_c_o = '1;
            state_d   = S_DONE;
          end
          OP_LOAD: begin
            j_vec_c_o = data_q;
            k_vec_c_o = ~data_q;
            state_d   = S_DONE;
          end
          default: begin
            // A zero step count spends one hold cycle in EXEC.
            if (cnt_q != '0) begin
              j_vec_c_o = mask_c;
              k_vec_c_o = mask_c;
              cnt_d     = cnt_q - CW'(1);
              if (chain_c) wrap_d = 1'b1;
            end
            if (cnt_q <= CW'(1)) state_d = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        wrapped_d = wrap_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wrapped_o   = wrapped_q;

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller that sequences a bank of WIDTH JK flip-flops (per bit: jk=00 hold, 01 reset, 10 set, 11 toggle). It accepts clear, load, count-up and count-down commands over a valid/ready handshake and drives the bank's J/K vectors cycle by cycle, reading back the bank's Q vector. Counting uses the JK toggle mode: each cycle's toggle mask is computed from the current Q. The bank flops and this controller share `clk`. The bank's own reset is separate and is not driven by this block.

## Interface
- WIDTH, 4: number of JK flip-flops in the bank (≥1).
- CW, 8: width of the step-count field.

- clk  input  1  clock; bank and controller both update on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 CLEAR, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN.
- cmd_data  input  WIDTH  LOAD value; ignored for other ops.
- cmd_steps  input  CW  number of count steps; ignored for CLEAR/LOAD.
- q_vec  input  WIDTH  current Q of the bank.
- j_vec  output  WIDTH  J inputs to the bank.
- k_vec  output  WIDTH  K inputs to the bank.
- busy  output  1  high in EXEC and DONE.
- done  output  1  one-cycle completion pulse.
- wrapped  output  1  last completed count op passed through a wrap; held until next accept.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1, j_vec=k_vec=0 (bank holds).
  - On cmd_valid&&cmd_ready, latch op, data and steps into internal registers, clear wrapped, and go to EXEC.
- EXEC, CLEAR: one cycle with j=0, k=all ones, then DONE.
- EXEC, LOAD: one cycle with j=data, k=~data, then DONE.
- EXEC, COUNT_UP/COUNT_DOWN:
  - A remaining-step counter is loaded with steps.
  - Each cycle, j=k=toggle mask:
    - up: bit i toggles iff q_vec[i-1:0] are all 1.
    - down: bit i toggles iff q_vec[i-1:0] are all 0.
    - bit 0 always toggles.
  - The counter decrements each cycle; EXEC leaves to DONE after the cycle in which the counter reaches 1.
  - steps=0: exactly one EXEC cycle with j=k=0, then DONE. q is unchanged.
- Wrap: an up step taken with q_vec all ones (or a down step with q_vec all zeros) sets an internal wrap flag. The result wraps modulo 2^WIDTH.
- DONE: j=k=0, done=1 for one cycle, wrapped register updated from the flag, next state IDLE.
- j_vec/k_vec are combinational from state, latched op/data, and q_vec. They are 0 whenever the state is not EXEC.
- cmd_valid while busy is ignored. No queueing.
- Commands are never aborted except by reset.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wrapped=0, j_vec=k_vec=0, step counter 0.
- Accept at edge t0.
  - CLEAR/LOAD: bank Q updates at edge t0+1. done is high between t0+1 and t0+2. cmd_ready is high again after t0+2.
- COUNT with N≥1 steps: Q advances at edges t0+1 … t0+N. done is high between t0+N and t0+N+1. The next accept is possible at t0+N+2 at the earliest.
- Back-to-back: min spacing between accepts is N+2 cycles (3 for CLEAR/LOAD or N=0).
- Reset asserted mid-operation: immediately IDLE, j=k=0, no done pulse, wrapped=0. Bank Q keeps its last value.
- A single-edge handshake: cmd_valid held across the DONE→IDLE transition is accepted on the first IDLE edge.

## Test plan
- Reset, then LOAD data=4'hA (bank starts at 0) → j=1010, k=0101 for one cycle. q=4'hA at t0+1. done pulses once. wrapped=0.
- From q=4'h3, COUNT_UP steps=5 → q sequence 4,5,6,7,8 at edges t0+1..t0+5. done at t0+5..t0+6. wrapped=0.
- From q=4'hE, COUNT_UP steps=3 → q=F,0,1. wrapped=1 after done. A following LOAD clears wrapped at accept.
- From q=4'h1, COUNT_DOWN steps=2 → q=0,F, wrapped=1. Then COUNT_UP steps=0 → one hold cycle, q stays F, done after 1 cycle, wrapped=0.
- Start COUNT_UP steps=10 and pulse rst_n low at step 4 → j=k=0 immediately, no done, cmd_ready=1. q holds its step-4 value. cmd_valid pulses during EXEC are ignored (no extra q changes).
